// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART line arbiter.
// Also provides a one-hot to index helper reused by schedulers.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LINE,
    SENT,
    DRAIN
  } arb_state_t;

  localparam logic [7:0] DEFAULT_TERMINATOR = 8'h0A;
  localparam int         MAX_REQ            = 8;

  // Index of the highest set bit; zero for an all-zero vector.
  function automatic logic [2:0] onehot_idx(
    input logic [MAX_REQ-1:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_line_arbiter_rr.sv
// rr_priority_pick: combinational round-robin selector.
// Ports: i_req request vector, i_last last granted index,
//        o_grant one-hot pick, o_found any request present.
module rr_priority_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic          o_found
);

  logic [IW-1:0] w_idx;

  // Scan starts one past the last grant and wraps.
  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(i_last) + k) % N);
      if (!o_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_line_arbiter.sv
// uart_tx_line_arbiter: shares one UART transmitter between
// character producers, granting one whole line at a time.
// Ports: clk_in/rst_in clock and async high reset;
//   req_char_in/req_valid_in/req_ready_out producer side;
//   tx_char_out/tx_valid_out/tx_busy_in transmitter side;
//   grant_out one-hot owner; timeout_out forced release pulse.
module uart_tx_line_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ        = 2,
  parameter logic [7:0] TERMINATOR     = DEFAULT_TERMINATOR,
  parameter int         TIMEOUT_CYCLES = 100_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [NUM_REQ-1:0][7:0] req_char_in,
  input  logic [NUM_REQ-1:0]      req_valid_in,
  output logic [NUM_REQ-1:0]      req_ready_out,
  output logic [7:0]              tx_char_out,
  output logic                    tx_valid_out,
  input  logic                    tx_busy_in,
  output logic [NUM_REQ-1:0]      grant_out,
  output logic                    timeout_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_last;
  logic [CW-1:0]      r_cnt;
  logic [7:0]         r_char;
  logic               r_txv;
  logic [NUM_REQ-1:0] r_rdy;
  logic               r_to;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_found;
  logic [IW-1:0]      w_pick_idx;
  logic               w_own_valid;
  logic [7:0]         w_own_char;
  logic               w_to_hit;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .i_req   (req_valid_in),
    .i_last  (r_last),
    .o_grant (w_pick),
    .o_found (w_found)
  );

  assign w_pick_idx  = IW'(onehot_idx(MAX_REQ'(w_pick)));
  assign w_own_valid = req_valid_in[r_owner];
  assign w_own_char  = req_char_in[r_owner];
  assign w_to_hit    = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_cnt   <= '0;
      r_char  <= 8'h00;
      r_txv   <= 1'b0;
      r_rdy   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_txv <= 1'b0;
      r_rdy <= '0;
      r_to  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_owner <= w_pick_idx;
            r_cnt   <= '0;
            r_state <= LINE;
          end
        end
        LINE: begin
          // Timeout takes priority over a late-arriving character.
          if (w_to_hit) begin
            r_to    <= 1'b1;
            r_grant <= '0;
            r_last  <= r_owner;
            r_state <= IDLE;
          end else if (w_own_valid && !tx_busy_in) begin
            r_rdy   <= r_grant;
            r_txv   <= 1'b1;
            r_char  <= w_own_char;
            r_cnt   <= '0;
            r_state <= SENT;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // One cycle so the transmitter can raise busy.
        SENT: r_state <= DRAIN;
        DRAIN: begin
          if (!tx_busy_in) begin
            if (r_char == TERMINATOR) begin
              r_grant <= '0;
              r_last  <= r_owner;
              r_state <= IDLE;
            end else begin
              r_state <= LINE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_out = r_rdy;
  assign tx_char_out   = r_char;
  assign tx_valid_out  = r_txv;
  assign grant_out     = r_grant;
  assign timeout_out   = r_to;

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// tb_uart_tx_line_arbiter: scoreboard bench for the line arbiter.
// Producers feed queues; expected bytes are checked on each tx pulse.
module tb_uart_tx_line_arbiter;

  localparam int NR   = 2;
  localparam int TO   = 50;
  localparam int BUSY = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0][7:0] req_char = '0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [7:0]        tx_char;
  logic              tx_valid;
  logic              tx_busy;
  logic [NR-1:0]     grant;
  logic              timeout;
  logic              busy_hold = 1'b0;
  logic              prev_valid = 1'b0;

  int busy_cnt = 0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int last_tx_cyc = 0;
  int to_cyc = 0;
  int to_pulses = 0;

  logic [7:0] pq0[$];
  logic [7:0] pq1[$];
  logic [9:0] sb[$];

  uart_tx_line_arbiter #(
    .NUM_REQ        (NR),
    .TERMINATOR     (8'h0A),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_char_in   (req_char),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .tx_char_out   (tx_char),
    .tx_valid_out  (tx_valid),
    .tx_busy_in    (tx_busy),
    .grant_out     (grant),
    .timeout_out   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy for BUSY cycles after each trigger.
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_valid) busy_cnt <= BUSY;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = (busy_cnt != 0) || busy_hold;

  // Producers: advance on ready, else hold the front character.
  always @(posedge clk) begin
    #1;
    if (req_ready[0] && pq0.size() != 0) pq0.delete(0);
    if (req_ready[1] && pq1.size() != 0) pq1.delete(0);
    req_valid[0] = (pq0.size() != 0);
    req_valid[1] = (pq1.size() != 0);
    req_char[0]  = (pq0.size() != 0) ? pq0[0] : 8'h00;
    req_char[1]  = (pq1.size() != 0) ? pq1[0] : 8'h00;
  end

  always @(negedge clk) begin : mon
    logic [9:0] e;
    if (!rst) begin
      if (tx_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got char %h grant %b, expected none",
                   tx_char, grant);
        end else begin
          e = sb.pop_front();
          if ({grant, tx_char} !== e || req_ready !== e[9:8]) begin
            errors++;
            $display("FAIL tx_byte: got char %h grant %b ready %b, expected char %h grant %b",
                     tx_char, grant, req_ready, e[7:0], e[9:8]);
          end
        end
        last_tx_cyc = cyc;
      end else if (req_ready !== '0) begin
        checks++;
        errors++;
        $display("FAIL ready_stray: got ready %b without tx pulse, expected 00",
                 req_ready);
      end
      if (prev_valid && tx_valid) begin
        checks++;
        errors++;
        $display("FAIL tx_double: got valid high 2 cycles, expected 1");
      end
      if (prev_valid && !tx_busy) begin
        checks++;
        errors++;
        $display("FAIL busy_late: got busy 0 after trigger, expected 1");
      end
      if (timeout) begin
        to_pulses++;
        to_cyc = cyc;
      end
      prev_valid = tx_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] oh(input int who);
    return (who == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic send(input int who, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (who == 0) pq0.push_back(s[i]);
      else pq1.push_back(s[i]);
      sb.push_back({oh(who), 8'(s[i])});
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    pq0.delete();
    pq1.delete();
    sb.delete();
    busy_hold = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || grant !== '0) && n < 500) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s: got %0d pending grant %b, expected drained",
               name, sb.size(), grant);
    end
  endtask

  task automatic wait_grant(input string name, input logic [1:0] exp);
    int n = 0;
    while (grant === '0 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (grant !== exp) begin
      errors++;
      $display("FAIL %s: got grant %b, expected %b", name, grant, exp);
    end
  endtask

  task automatic wait_tx(input string name);
    int n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: got no tx pulse, expected one", name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    checks++;
    if ({grant, tx_char, tx_valid, req_ready, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant %b char %h valid %b, expected 0",
               grant, tx_char, tx_valid);
    end
    rst = 1'b0;
    tick(3);
    checks++;
    if (grant !== '0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: got grant %b valid %b, expected 00/0",
               grant, tx_valid);
    end
  endtask

  task automatic test_single_line;
    int bad = 0;
    int n = 0;
    send(0, "ok\n");
    wait_grant("single_grant", 2'b01);
    while (sb.size() != 0 && n < 300) begin
      if (grant !== 2'b01) bad++;
      tick(1);
      n++;
    end
    checks++;
    if (bad != 0 || sb.size() != 0) begin
      errors++;
      $display("FAIL single_hold: got %0d bad cycles %0d left, expected 0/0",
               bad, sb.size());
    end
    wait_idle("single_release");
  endtask

  task automatic test_contention;
    do_reset();
    send(0, "A\n");
    send(1, "B\n");
    send(0, "C\n");
    wait_grant("cont_first", 2'b01);
    wait_idle("cont_round1");
    send(1, "Y\n");
    send(0, "X\n");
    wait_grant("cont_rotate", 2'b10);
    wait_idle("cont_round2");
  endtask

  task automatic test_timeout;
    int p0 = to_pulses;
    int n = 0;
    send(1, "ab");
    wait_grant("to_grant", 2'b10);
    while (to_pulses == p0 && n < 300) begin
      tick(1);
      n++;
    end
    checks++;
    if (to_pulses == p0) begin
      errors++;
      $display("FAIL to_fire: got no timeout pulse, expected one");
    end
    // Pulse lands after SENT, BUSY drain cycles, DRAIN exit, then TO idle cycles.
    checks++;
    if (to_cyc - last_tx_cyc != BUSY + 2 + TO) begin
      errors++;
      $display("FAIL to_delay: got %0d cycles, expected %0d",
               to_cyc - last_tx_cyc, BUSY + 2 + TO);
    end
    tick(1);
    checks++;
    if (timeout !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL to_release: got timeout %b grant %b, expected 0/00",
               timeout, grant);
    end
    send(0, "z\n");
    wait_grant("to_next", 2'b01);
    wait_idle("to_done");
  endtask

  task automatic test_busy_hold;
    int stray = 0;
    send(0, "pq\n");
    wait_tx("hold_first");
    busy_hold = 1'b1;
    repeat (200) begin
      tick(1);
      if (tx_valid !== 1'b0 || req_ready !== '0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL hold_stall: got %0d pulses, expected 0", stray);
    end
    busy_hold = 1'b0;
    tick(1);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_early: got valid %b, expected 0", tx_valid);
    end
    tick(1);
    checks++;
    if (tx_valid !== 1'b1 || tx_char !== 8'h71) begin
      errors++;
      $display("FAIL hold_resume: got valid %b char %h, expected 1/71",
               tx_valid, tx_char);
    end
    wait_idle("hold_done");
  endtask

  task automatic test_reset_mid;
    send(0, "rs\n");
    wait_tx("mid_first");
    tick(2);
    checks++;
    if (grant !== 2'b01 || tx_char !== 8'h72) begin
      errors++;
      $display("FAIL mid_pre: got grant %b char %h, expected 01/72",
               grant, tx_char);
    end
    #1;
    rst = 1'b1;
    pq0.delete();
    pq1.delete();
    sb.delete();
    #1;
    checks++;
    if ({grant, tx_char, tx_valid, req_ready, timeout} !== '0) begin
      errors++;
      $display("FAIL mid_async: got grant %b char %h valid %b, expected 0",
               grant, tx_char, tx_valid);
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    send(0, "n\n");
    send(1, "m\n");
    wait_grant("mid_prio", 2'b01);
    wait_idle("mid_done");
    tick(40);
  endtask

  initial begin
    test_reset();
    test_single_line();
    test_contention();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    checks++;
    if (to_pulses != 1) begin
      errors++;
      $display("FAIL to_count: got %0d timeouts, expected 1", to_pulses);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of tests");
    $fatal(1, "watchdog");
  end

endmodule
